// File: rtl/mealy_atm_pkg.sv
// Shared types and default parameters for the ATM front-end controller.
package mealy_atm_pkg;

   localparam int unsigned AMT_W_DEF     = 16;
   localparam int unsigned PIN_W_DEF     = 4;
   localparam int unsigned MAX_TRIES_DEF = 3;
   localparam int unsigned TRIES_W       = 2;

   typedef enum logic [1:0] {
      CHECK     = 2'd0,
      WAIT_CARD = 2'd1,
      PIN       = 2'd2,
      AMOUNT    = 2'd3
   } atm_state_e;

endpackage

// File: rtl/mealy_atm_fsm.sv
// Mealy ATM controller: health/cash check, card acceptance, PIN attempts, amount decision.
// All status outputs are combinational from the current state and inputs.
module mealy_atm_fsm
   import mealy_atm_pkg::*;
#(
   parameter int unsigned AMT_W     = AMT_W_DEF,
   parameter int unsigned PIN_W     = PIN_W_DEF,
   parameter int unsigned MAX_TRIES = MAX_TRIES_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             defect,
   input  logic             insert_card,
   input  logic             card_valid,
   input  logic             card_undamaged,
   input  logic [AMT_W-1:0] cash,
   input  logic [AMT_W-1:0] amount_asked,
   input  logic [PIN_W-1:0] correct_pin,
   input  logic [PIN_W-1:0] user_pin,
   output logic             green_bulb,
   output logic             red_bulb,
   output logic             resubmit,
   output logic             alarm,
   output logic             not_enough_cash,
   output logic             success
);

   localparam logic [TRIES_W-1:0] TRY_LAST = TRIES_W'(MAX_TRIES - 1);

   atm_state_e         state_q, state_d;
   logic [TRIES_W-1:0] tries_q, tries_d;

   logic green_d, red_d, resubmit_d, alarm_d, nec_d, success_d;

   logic cash_empty;
   logic pin_match;
   logic amt_zero;
   logic amt_over;

   assign cash_empty = (cash == '0);
   assign pin_match  = (user_pin == correct_pin);
   assign amt_zero   = (amount_asked == '0);
   assign amt_over   = (amount_asked > cash);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= CHECK;
         tries_q <= '0;
      end else begin
         state_q <= state_d;
         tries_q <= tries_d;
      end
   end

   // defect is evaluated before the state case so it overrides every branch.
   always_comb begin
      state_d    = state_q;
      tries_d    = tries_q;
      green_d    = 1'b0;
      red_d      = 1'b0;
      resubmit_d = 1'b0;
      alarm_d    = 1'b0;
      nec_d      = 1'b0;
      success_d  = 1'b0;

      if (defect) begin
         red_d   = 1'b1;
         state_d = CHECK;
      end else begin
         unique case (state_q)
            CHECK: begin
               if (cash_empty) begin
                  red_d = 1'b1;
               end else begin
                  green_d = 1'b1;
                  state_d = WAIT_CARD;
                  tries_d = '0;
               end
            end

            WAIT_CARD: begin
               if (cash_empty) begin
                  red_d   = 1'b1;
                  state_d = CHECK;
               end else begin
                  green_d = 1'b1;
                  if (insert_card) begin
                     if (card_valid && card_undamaged) begin
                        state_d = PIN;
                        tries_d = '0;
                     end else begin
                        resubmit_d = 1'b1;
                     end
                  end
               end
            end

            PIN: begin
               if (!insert_card) begin
                  state_d = CHECK;
               end else if (pin_match) begin
                  state_d = AMOUNT;
               end else if (tries_q == TRY_LAST) begin
                  alarm_d = 1'b1;
                  state_d = CHECK;
               end else begin
                  tries_d = tries_q + 1'b1;
               end
            end

            AMOUNT: begin
               if (!insert_card) begin
                  state_d = CHECK;
               end else if (!amt_zero) begin
                  if (amt_over) begin
                     nec_d = 1'b1;
                  end else begin
                     success_d = 1'b1;
                     state_d   = CHECK;
                  end
               end
            end

            default: state_d = CHECK;
         endcase
      end
   end

   // Reset is asynchronous, so the combinational outputs are gated by it too.
   always_comb begin
      green_bulb      = reset & green_d;
      red_bulb        = reset & red_d;
      resubmit        = reset & resubmit_d;
      alarm           = reset & alarm_d;
      not_enough_cash = reset & nec_d;
      success         = reset & success_d;
   end

endmodule

// File: tb/tb_mealy_atm_fsm.sv
// Directed bench for mealy_atm_fsm: inputs change on the falling edge, outputs sampled 1ns later.
module tb_mealy_atm_fsm;
   import mealy_atm_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        defect, insert_card, card_valid, card_undamaged;
   logic [15:0] cash, amount_asked;
   logic [3:0]  correct_pin, user_pin;
   logic        green_bulb, red_bulb, resubmit, alarm, not_enough_cash, success;
   logic [5:0]  outs_v;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   localparam logic [5:0] Z  = 6'b000000;
   localparam logic [5:0] G  = 6'b100000;
   localparam logic [5:0] R  = 6'b010000;
   localparam logic [5:0] RS = 6'b101000;
   localparam logic [5:0] AL = 6'b000100;
   localparam logic [5:0] NE = 6'b000010;
   localparam logic [5:0] SU = 6'b000001;

   mealy_atm_fsm #(.AMT_W(16), .PIN_W(4), .MAX_TRIES(3)) dut (
      .clock(clock), .reset(reset), .defect(defect), .insert_card(insert_card),
      .card_valid(card_valid), .card_undamaged(card_undamaged), .cash(cash),
      .amount_asked(amount_asked), .correct_pin(correct_pin), .user_pin(user_pin),
      .green_bulb(green_bulb), .red_bulb(red_bulb), .resubmit(resubmit), .alarm(alarm),
      .not_enough_cash(not_enough_cash), .success(success)
   );

   always #5 clock = ~clock;

   assign outs_v = {green_bulb, red_bulb, resubmit, alarm, not_enough_cash, success};

   task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs already applied at the falling edge; check outputs, then cross the rising edge.
   task automatic cyc(input string tag, input logic [5:0] exp);
      #1;
      expect_eq(tag, 32'(outs_v), 32'(exp));
      @(negedge clock);
   endtask

   task automatic st(input string tag, input atm_state_e s);
      expect_eq(tag, 32'(dut.state_q), 32'(s));
   endtask

   initial begin
      reset = 1'b0; defect = 1'b1; insert_card = 1'b0; card_valid = 1'b0;
      card_undamaged = 1'b0; cash = 16'd100; amount_asked = '0;
      correct_pin = 4'b0110; user_pin = '0;
      #1;
      expect_eq("rst_outs", 32'(outs_v), 32'(Z));
      st("rst_state", CHECK);
      expect_eq("rst_tries", 32'(dut.tries_q), 32'd0);

      @(negedge clock);
      reset = 1'b1;
      cyc("defect_chk", R);         st("defect_chk_st", CHECK);
      defect = 1'b0; cash = '0;
      cyc("cash0_chk", R);          st("cash0_chk_st", CHECK);
      cash = 16'd100;
      cyc("chk_go", G);             st("chk_go_st", WAIT_CARD);
      cyc("wait_idle", G);          st("wait_idle_st", WAIT_CARD);

      insert_card = 1'b1; card_valid = 1'b0; card_undamaged = 1'b1;
      cyc("resub1", RS);
      cyc("resub2", RS);
      card_valid = 1'b1; card_undamaged = 1'b0;
      cyc("resub_dmg", RS);         st("resub_st", WAIT_CARD);
      card_undamaged = 1'b1;
      cyc("card_ok", G);            st("card_ok_st", PIN);

      user_pin = 4'b0000;
      cyc("pin_w1", Z);
      cyc("pin_w2", Z);
      cyc("pin_w3", AL);            st("alarm_st", CHECK);
      cyc("after_alarm", G);
      cyc("card2", G);              st("card2_st", PIN);

      user_pin = 4'b0110; amount_asked = 16'd110;
      cyc("pin_ok", Z);             st("pin_ok_st", AMOUNT);
      cyc("nec1", NE);
      cyc("nec2", NE);              st("nec_st", AMOUNT);
      amount_asked = '0;
      cyc("amt0", Z);               st("amt0_st", AMOUNT);
      amount_asked = 16'd2;
      cyc("succ", SU);              st("succ_st", CHECK);

      amount_asked = 16'd100;
      cyc("t2_chk", G);
      cyc("t2_wait", G);
      cyc("t2_pin", Z);             st("t2_amt_st", AMOUNT);
      defect = 1'b1;
      cyc("defect_amt", R);         st("defect_amt_st", CHECK);
      defect = 1'b0;
      cyc("t3_chk", G);
      cyc("t3_wait", G);
      cyc("t3_pin", Z);
      cyc("succ_eq", SU);           st("succ_eq_st", CHECK);

      cyc("t4_chk", G);
      cyc("t4_wait", G);
      user_pin = 4'b0000;
      cyc("t4_w1", Z);
      insert_card = 1'b0; user_pin = 4'b0110;
      cyc("pin_abort", Z);          st("pin_abort_st", CHECK);

      insert_card = 1'b1;
      cyc("t5_chk", G);
      cyc("t5_wait", G);
      user_pin = 4'b0000;
      cyc("t5_w1", Z);
      cyc("t5_w2", Z);
      expect_eq("t5_tries", 32'(dut.tries_q), 32'd2);
      defect = 1'b1;
      cyc("defect_alarm", R);       st("defect_alarm_st", CHECK);
      defect = 1'b0;

      cyc("t6_chk", G);
      cyc("t6_wait", G);
      cyc("t6_w1", Z);
      cyc("t6_w2", Z);
      #2 reset = 1'b0;
      #1;
      expect_eq("rst_mid_outs", 32'(outs_v), 32'(Z));
      st("rst_mid_st", CHECK);
      expect_eq("rst_mid_tries", 32'(dut.tries_q), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      cyc("t7_chk", G);             st("t7_wait_st", WAIT_CARD);
      cash = '0;
      cyc("wait_cash0", R);         st("wait_cash0_st", CHECK);

      cash = 16'd100;
      cyc("t8_chk", G);
      cyc("t8_wait", G);
      user_pin = 4'b0110;
      cyc("t8_pin", Z);
      insert_card = 1'b0; amount_asked = 16'd50;
      cyc("amt_abort", Z);          st("amt_abort_st", CHECK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
